// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder
//   AHB-Lite slave memory of 32-bit words. It sits below the instruction cache
//   and answers its NONSEQ/SEQ transfers, including WRAP4 line fills. Every data
//   phase is stretched by a fixed WAIT_STATES. Writes land in the same array,
//   which lets benches and boot logic preload the contents.
//
// Parameters
//   MEM_WORDS   : depth in words, a power of two no smaller than 2
//   WAIT_STATES : wait cycles per data phase, 0..15
//   BASE_ADDR   : byte address of word 0
//
// Ports
//   hclk, hrst            : clock; synchronous active-high reset
//   hsel, haddr, htrans   : address-phase select, byte address and transfer type
//   hwrite, hsize, hburst : direction, size and burst type (hburst is unused)
//   hwdata                : write data for the data phase
//   hready                : bus ready; qualifies the address phase
//   hreadyout, hrdata     : slave ready and read data, both registered
//   hresp                 : OKAY/ERROR, registered
//
// Build option
//   AHB_MEM_ERR_EN : when defined, the slave answers with a two-cycle ERROR for
//   out-of-range, misaligned or non-word transfers. When not defined, the index
//   wraps modulo MEM_WORDS and hresp is held at 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no data phase pending
// WAIT  | data phase stretched, hreadyout low, wait_cnt counting down
// DATA  | closing data phase: read data is driven, or a write commits
// ERR1  | first ERROR cycle, hreadyout low   (AHB_MEM_ERR_EN only)
// ERR2  | second ERROR cycle, hreadyout high (AHB_MEM_ERR_EN only)
module ahb_mem_responder #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

`ifdef AHB_MEM_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

  state_t        state;
  state_t        acc_state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [31:0]   mem [MEM_WORDS];

  logic          accept;
  logic [31:0]   offset;
  logic [AW-1:0] idx_d;
  logic          addr_err;
  logic [31:0]   rd_fwd;
  logic          unused_ok;

  assign accept = hsel & hready & htrans[1];
  assign offset = haddr - BASE_ADDR;
  assign idx_d  = offset[AW+1:2];

`ifdef AHB_MEM_ERR_EN
  logic [32:0] limit;
  assign limit    = 33'(BASE_ADDR) + 33'(MEM_WORDS) * 33'd4;
  assign addr_err = (haddr < BASE_ADDR) || ({1'b0, haddr} >= limit) ||
                    (haddr[1:0] != 2'b00) || (hsize != 3'b010);
`else
  assign addr_err = 1'b0;
`endif

  assign unused_ok = ^{hburst, hsize, offset[1:0], offset[31:AW+2], addr_err};

  // When WAIT_STATES is 0, a read can be accepted on the same edge that
  // commits a write to the same word. Forward the write data so that the read
  // sees the new value.
  assign rd_fwd = (state == S_DATA && wr_q && idx_q == idx_d) ? hwdata : mem[idx_d];

  // Next state for a transfer accepted on this edge.
  always_comb begin
    acc_state = S_DATA;
`ifdef AHB_MEM_ERR_EN
    if (addr_err)
      acc_state = S_ERR1;
    else
`endif
    if (WAIT_STATES != 0)
      acc_state = S_WAIT;
  end

  always_ff @(posedge hclk) begin
    if (!hrst && state == S_DATA && wr_q)
      mem[idx_q] <= hwdata;
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= 32'h0;
    end else begin
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= 32'h0;
      case (state)
        S_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state    <= S_DATA;
            wait_cnt <= 4'd0;
            if (!wr_q)
              hrdata <= mem[idx_q];
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
            hreadyout <= 1'b0;
          end
        end
`ifdef AHB_MEM_ERR_EN
        S_ERR1: begin
          state <= S_ERR2;
          hresp <= 1'b1;
        end
`endif
        default: begin
          // IDLE, DATA and ERR2 all end with hready high, so the next address
          // phase may be accepted here (pipelined back-to-back).
          if (accept) begin
            idx_q    <= idx_d;
            wr_q     <= hwrite;
            wait_cnt <= 4'(WAIT_STATES);
            state    <= acc_state;
            case (acc_state)
              S_WAIT: hreadyout <= 1'b0;
              S_DATA: if (!hwrite) hrdata <= rd_fwd;
`ifdef AHB_MEM_ERR_EN
              S_ERR1: begin
                hreadyout <= 1'b0;
                hresp     <= 1'b1;
              end
`endif
              default: ;
            endcase
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
